// File: rtl/hazard_pkg.sv
// Shared defaults and helpers for the decode-stage operand hazard unit.
package hazard_pkg;
    localparam int DEF_AW       = 5;
    localparam int DEF_DW       = 32;
    localparam int DEF_NFWD     = 2;
    localparam int DEF_LD_DEPTH = 4;

    localparam logic [DEF_AW-1:0] R0 = '0;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value)
            result = result + 1;
        return result;
    endfunction
endpackage

// File: rtl/ld_tag_fifo.sv
// In-order tag FIFO of outstanding load destinations with per-entry
// address compares for both decode source operands.
module ld_tag_fifo
    import hazard_pkg::*;
#(
    parameter int AW    = DEF_AW,
    parameter int DEPTH = DEF_LD_DEPTH,
    parameter int CW    = clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [AW-1:0]    push_dest,
    input  logic             pop,
    input  logic             flush,
    input  logic [AW-1:0]    cmp_addr1,
    input  logic [AW-1:0]    cmp_addr2,
    output logic [DEPTH-1:0] match1,
    output logic [DEPTH-1:0] match2,
    output logic [DEPTH-1:0] head_oh,
    output logic             head_match1,
    output logic             head_match2,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             err
);
    localparam int PW = clog2(DEPTH);

    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [DEPTH-1:0] ent_valid;
    logic [AW-1:0]    ent_dest [DEPTH];
    logic             pop_ok;

    // A pop with nothing tracked is an error and must not move the head.
    assign pop_ok = pop && (count != '0);
    assign full   = (count == CW'(DEPTH));

    always_comb begin
        match1 = '0;
        match2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match1[i] = ent_valid[i] && (ent_dest[i] == cmp_addr1);
            match2[i] = ent_valid[i] && (ent_dest[i] == cmp_addr2);
        end
    end

    assign head_oh     = DEPTH'(1) << head;
    assign head_match1 = match1[head];
    assign head_match2 = match2[head];

    always_ff @(posedge clk) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            ent_valid <= '0;
            err       <= 1'b0;
        end else begin
            if (pop && (count == '0))
                err <= 1'b1;
            if (flush) begin
                head      <= '0;
                tail      <= '0;
                count     <= '0;
                ent_valid <= '0;
            end else begin
                // When full, head == tail: the push assignment below wins the slot.
                if (pop_ok) begin
                    ent_valid[head] <= 1'b0;
                    head            <= head + 1'b1;
                end
                if (push) begin
                    ent_valid[tail] <= 1'b1;
                    ent_dest[tail]  <= push_dest;
                    tail            <= tail + 1'b1;
                end
                if (push && !pop_ok)
                    count <= count + 1'b1;
                else if (!push && pop_ok)
                    count <= count - 1'b1;
            end
        end
    end
endmodule

// File: rtl/id_hazard_scoreboard.sv
// Decode-stage operand hazard resolution: load-use stalls, load-data bypass,
// forwarding mux over NFWD later stages, and the readygo/issue handshake.
module id_hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int AW       = DEF_AW,
    parameter int DW       = DEF_DW,
    parameter int NFWD     = DEF_NFWD,
    parameter int LD_DEPTH = DEF_LD_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       id_valid,
    input  logic [AW-1:0]              id_raddr1,
    input  logic [AW-1:0]              id_raddr2,
    input  logic                       id_ren1,
    input  logic                       id_ren2,
    input  logic [AW-1:0]              id_dest,
    input  logic                       id_is_load,
    input  logic                       ex_allowin,
    input  logic [NFWD-1:0]            fwd_valid,
    input  logic [NFWD*AW-1:0]         fwd_addr,
    input  logic [NFWD*DW-1:0]         fwd_data,
    input  logic [DW-1:0]              rf_rdata1,
    input  logic [DW-1:0]              rf_rdata2,
    input  logic                       ld_done,
    input  logic [DW-1:0]              ld_data,
    input  logic                       ld_flush,
    output logic                       id_readygo,
    output logic                       id_issue,
    output logic [DW-1:0]              opnd1,
    output logic [DW-1:0]              opnd2,
    output logic [clog2(LD_DEPTH):0]   ld_count,
    output logic                       ld_full,
    output logic                       ld_err
);
    logic [LD_DEPTH-1:0] match [2];
    logic [LD_DEPTH-1:0] head_oh;
    logic                head_match [2];
    logic [AW-1:0]       src_addr [2];
    logic                src_ren [2];
    logic [DW-1:0]       src_rf [2];
    logic [DW-1:0]       src_opnd [2];
    logic [1:0]          blocked;
    logic                push;

    assign src_addr[0] = id_raddr1;
    assign src_addr[1] = id_raddr2;
    assign src_ren[0]  = id_ren1;
    assign src_ren[1]  = id_ren2;
    assign src_rf[0]   = rf_rdata1;
    assign src_rf[1]   = rf_rdata2;

    assign push = id_issue && id_is_load && (id_dest != AW'(R0));

    ld_tag_fifo #(
        .AW    (AW),
        .DEPTH (LD_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .push_dest   (id_dest),
        .pop         (ld_done),
        .flush       (ld_flush),
        .cmp_addr1   (id_raddr1),
        .cmp_addr2   (id_raddr2),
        .match1      (match[0]),
        .match2      (match[1]),
        .head_oh     (head_oh),
        .head_match1 (head_match[0]),
        .head_match2 (head_match[1]),
        .count       (ld_count),
        .full        (ld_full),
        .err         (ld_err)
    );

    always_comb begin
        blocked = '0;
        for (int s = 0; s < 2; s++) begin
            src_opnd[s] = src_rf[s];
            // Any younger pending load to this register stalls, even with ld_done.
            if (src_ren[s] && (src_addr[s] != AW'(R0)))
                blocked[s] = (|(match[s] & ~head_oh)) || (head_match[s] && !ld_done);
            for (int i = NFWD - 1; i >= 0; i--) begin
                if (fwd_valid[i] && (fwd_addr[i*AW +: AW] == src_addr[s]))
                    src_opnd[s] = fwd_data[i*DW +: DW];
            end
            if (head_match[s] && ld_done)
                src_opnd[s] = ld_data;
            if (src_addr[s] == AW'(R0))
                src_opnd[s] = '0;
        end
    end

    assign opnd1      = src_opnd[0];
    assign opnd2      = src_opnd[1];
    assign id_readygo = !(|blocked) && !(id_is_load && ld_full && !ld_done);
    assign id_issue   = id_valid && id_readygo && ex_allowin;
endmodule
